// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - front-end/ID signal bundle between pipeline and branch predictor
// Ports (slave = predictor side):
//   stall, if_pc, if_instr          IF side inputs to the predictor
//   id_pc, alt_address, is_link,
//   is_branch, is_taken             ID resolution inputs to the predictor
//   take, flush, alt_pc             redirect/flush outputs from the predictor
interface branch_predictor_if;
  logic        stall;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] id_pc;
  logic [31:0] alt_address;
  logic        is_link;
  logic        is_branch;
  logic        is_taken;
  logic        take;
  logic        flush;
  logic [31:0] alt_pc;

  modport master (
    output stall, if_pc, if_instr, id_pc, alt_address, is_link, is_branch, is_taken,
    input  take, flush, alt_pc
  );

  modport slave (
    input  stall, if_pc, if_instr, id_pc, alt_address, is_link, is_branch, is_taken,
    output take, flush, alt_pc
  );
endinterface

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - tournament branch predictor (local/gshare/meta, BTB, optional RAS)
// Ports:
//   clk    clock, all state changes on the rising edge
//   reset  asynchronous active-low reset
//   bus    branch_predictor_if.slave: stall, if_pc, if_instr, id_pc, alt_address,
//          is_link, is_branch, is_taken in; take, flush, alt_pc out
// Optional feature macro: BRANCH_PREDICTOR_RAS_EN (return-address stack for `jr $31`)
module branch_predictor #(
  parameter int BTB_BITS   = 6,
  parameter int BHT_BITS   = 10,
  parameter int GHR_BITS   = 10,
  parameter int RAS_DEPTH  = 8,
  parameter int PIPE_DEPTH = 7
) (
  input  logic              clk,
  input  logic              reset,
  branch_predictor_if.slave bus
);

  localparam int BTB_N = 1 << BTB_BITS;
  localparam int BHT_N = 1 << BHT_BITS;

  // Everything ID needs to judge and train a prediction made PIPE_DEPTH stages earlier.
  typedef struct packed {
    logic                pred_taken;
    logic [31:0]         pred_target;
    logic [BHT_BITS-1:0] lidx;
    logic [BHT_BITS-1:0] gidx;
    logic                lbit;
    logic                gbit;
    logic                ras_used;
  } pred_rec_t;

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'd1;
    else    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]          local_ctr  [BHT_N];
  logic [1:0]          global_ctr [BHT_N];
  logic [1:0]          meta_ctr   [BHT_N];
  logic [GHR_BITS-1:0] ghr;

  logic                btb_valid  [BTB_N];
  logic [31:0]         btb_tag    [BTB_N];
  logic [31:0]         btb_target [BTB_N];

  pred_rec_t           pipe [PIPE_DEPTH];

  // ---------------------------------------------------------------------------
  // IF-stage prediction
  // ---------------------------------------------------------------------------
  logic [BHT_BITS-1:0] if_lidx;
  logic [BHT_BITS-1:0] if_gidx;
  logic [BTB_BITS-1:0] if_bidx;
  logic                if_lbit;
  logic                if_gbit;
  logic                if_dir;
  logic                btb_hit;
  pred_rec_t           if_rec;

  assign if_lidx = bus.if_pc[BHT_BITS+1:2];
  assign if_gidx = if_lidx ^ BHT_BITS'(ghr);
  assign if_bidx = bus.if_pc[BTB_BITS+1:2];
  assign if_lbit = local_ctr[if_lidx][1];
  assign if_gbit = global_ctr[if_gidx][1];
  // Meta counter MSB set means "trust gshare" for this PC.
  assign if_dir  = meta_ctr[if_lidx][1] ? if_gbit : if_lbit;
  assign btb_hit = btb_valid[if_bidx] && (btb_tag[if_bidx] == bus.if_pc);

  // ---------------------------------------------------------------------------
  // ID-stage resolution
  // ---------------------------------------------------------------------------
  pred_rec_t           id_rec;
  logic [BTB_BITS-1:0] id_bidx;
  logic                mispredict;
  logic                train;

  assign id_rec  = pipe[PIPE_DEPTH-1];
  assign id_bidx = bus.id_pc[BTB_BITS+1:2];
  assign train   = !bus.stall && bus.is_branch;

  // A non-branch arriving with a taken prediction is a BTB alias and must be undone too.
  always_comb begin
    mispredict = 1'b0;
    if (!bus.stall) begin
      if (bus.is_branch)
        mispredict = (bus.is_taken != id_rec.pred_taken) ||
                     (bus.is_taken && (bus.alt_address != id_rec.pred_target));
      else
        mispredict = id_rec.pred_taken;
    end
  end

`ifdef BRANCH_PREDICTOR_RAS_EN
  // ---------------------------------------------------------------------------
  // Return-address stack (circular; overflow silently drops the oldest entry)
  // ---------------------------------------------------------------------------
  localparam int RAS_PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int RAS_CW = $clog2(RAS_DEPTH + 1);

  logic [31:0]       ras [RAS_DEPTH];
  logic [RAS_PW-1:0] ras_top;
  logic [RAS_CW-1:0] ras_count;
  logic              ras_push;
  logic              ras_pop;
  logic              ras_we;
  logic [RAS_PW-1:0] ras_waddr;
  logic              jr_ra;
  logic              unused_instr;

  function automatic logic [RAS_PW-1:0] ras_inc(input logic [RAS_PW-1:0] p);
    return (p == RAS_PW'(RAS_DEPTH - 1)) ? '0 : p + RAS_PW'(1);
  endfunction

  function automatic logic [RAS_PW-1:0] ras_dec(input logic [RAS_PW-1:0] p);
    return (p == '0) ? RAS_PW'(RAS_DEPTH - 1) : p - RAS_PW'(1);
  endfunction

  assign jr_ra    = (bus.if_instr[31:26] == 6'd0) && (bus.if_instr[25:21] == 5'd31) &&
                    (bus.if_instr[5:0] == 6'd8);
  assign ras_push = !bus.stall && bus.is_branch && bus.is_taken && bus.is_link;
  assign ras_pop  = !bus.stall && id_rec.ras_used;
  assign unused_instr = ^bus.if_instr[20:6];

  // Push and pop together with a live top simply replaces the top entry.
  always_comb begin
    ras_we    = 1'b0;
    ras_waddr = ras_top;
    if (ras_push) begin
      ras_we = 1'b1;
      if (!(ras_pop && ras_count != '0)) ras_waddr = ras_inc(ras_top);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ras_top   <= '0;
      ras_count <= '0;
    end else if (ras_push) begin
      if (!(ras_pop && ras_count != '0)) begin
        ras_top <= ras_inc(ras_top);
        if (ras_count != RAS_CW'(RAS_DEPTH)) ras_count <= ras_count + RAS_CW'(1);
      end
    end else if (ras_pop && ras_count != '0) begin
      ras_top   <= ras_dec(ras_top);
      ras_count <= ras_count - RAS_CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (ras_we) ras[ras_waddr] <= bus.id_pc + 32'd8;
  end
`else
  logic unused_ras_inputs;
  assign unused_ras_inputs = ^{bus.if_instr, bus.is_link, id_rec.ras_used};
`endif

  always_comb begin
    if_rec             = '0;
    if_rec.lidx        = if_lidx;
    if_rec.gidx        = if_gidx;
    if_rec.lbit        = if_lbit;
    if_rec.gbit        = if_gbit;
    if_rec.pred_taken  = btb_hit && if_dir;
    if_rec.pred_target = btb_target[if_bidx];
`ifdef BRANCH_PREDICTOR_RAS_EN
    if (jr_ra && ras_count != '0) begin
      if_rec.pred_taken  = 1'b1;
      if_rec.pred_target = ras[ras_top];
      if_rec.ras_used    = 1'b1;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Outputs: ID recovery outranks the IF prediction
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.take   = 1'b0;
    bus.flush  = 1'b0;
    bus.alt_pc = '0;
    if (reset) begin
      if (mispredict) begin
        bus.take   = 1'b1;
        bus.flush  = 1'b1;
        bus.alt_pc = (bus.is_branch && bus.is_taken) ? bus.alt_address : bus.id_pc + 32'd4;
      end else if (!bus.stall && if_rec.pred_taken) begin
        bus.take   = 1'b1;
        bus.alt_pc = if_rec.pred_target;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Prediction pipe
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PIPE_DEPTH; i++) pipe[i] <= '0;
    end else if (!bus.stall) begin
      if (mispredict) begin
        for (int i = 0; i < PIPE_DEPTH; i++) pipe[i] <= '0;
      end else begin
        pipe[0] <= if_rec;
        for (int i = 1; i < PIPE_DEPTH; i++) pipe[i] <= pipe[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Direction tables and history (trained at recorded indices, non-speculative GHR)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BHT_N; i++) begin
        local_ctr[i]  <= 2'b01;
        global_ctr[i] <= 2'b01;
        meta_ctr[i]   <= 2'b01;
      end
      ghr <= '0;
    end else if (train) begin
      local_ctr[id_rec.lidx]  <= sat_step(local_ctr[id_rec.lidx], bus.is_taken);
      global_ctr[id_rec.gidx] <= sat_step(global_ctr[id_rec.gidx], bus.is_taken);
      // Only a disagreement says anything about which component to trust.
      if (id_rec.lbit != id_rec.gbit)
        meta_ctr[id_rec.lidx] <= sat_step(meta_ctr[id_rec.lidx], id_rec.gbit == bus.is_taken);
      ghr <= {ghr[GHR_BITS-2:0], bus.is_taken};
    end
  end

  // ---------------------------------------------------------------------------
  // BTB
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BTB_N; i++) btb_valid[i] <= 1'b0;
    end else if (!bus.stall) begin
      if (bus.is_branch && bus.is_taken)
        btb_valid[id_bidx] <= 1'b1;
      else if (!bus.is_branch && id_rec.pred_taken)
        btb_valid[id_bidx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (train && bus.is_taken) begin
      btb_tag[id_bidx]    <= bus.id_pc;
      btb_target[id_bidx] <= bus.alt_address;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed scoreboard bench for branch_predictor
module tb_branch_predictor;

  localparam logic [31:0] B1  = 32'h0040_0010;
  localparam logic [31:0] T1  = 32'h0040_0100;
  localparam logic [31:0] B2  = 32'h0040_0080;
  localparam logic [31:0] T2A = 32'h0040_0300;
  localparam logic [31:0] T2B = 32'h0040_0400;

  typedef struct packed {
    logic         take;
    logic         flush;
    logic [31:0]  alt;
    logic [127:0] tag;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] fpc;
  exp_t        sb[$];
  int          n_cmp;
  int          n_err;

  branch_predictor_if bus ();

  branch_predictor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic set_if(input logic [31:0] pc, input logic [31:0] instr);
    bus.if_pc    = pc;
    bus.if_instr = instr;
  endtask

  task automatic set_id(input logic [31:0] pc, input logic [31:0] alt,
                        input logic link, input logic br, input logic tk);
    bus.id_pc       = pc;
    bus.alt_address = alt;
    bus.is_link     = link;
    bus.is_branch   = br;
    bus.is_taken    = tk;
  endtask

  task automatic id_idle();
    set_id(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Expectation is queued with the stimulus, then popped and compared mid-cycle.
  task automatic check(input logic [127:0] tag, input logic t, input logic f,
                       input logic [31:0] a);
    exp_t e;
    e.take  = t;
    e.flush = f;
    e.alt   = a;
    e.tag   = tag;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++;
    assert ({bus.take, bus.flush, bus.alt_pc} === {e.take, e.flush, e.alt})
    else begin
      n_err++;
      $error("FAIL %0s: observed take=%0b flush=%0b alt_pc=%08h expected take=%0b flush=%0b alt_pc=%08h",
             e.tag, bus.take, bus.flush, bus.alt_pc, e.take, e.flush, e.alt);
    end
    @(posedge clk);
    #1;
  endtask

  // Non-branch fetches at PCs never trained; ID sees bubbles.
  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      set_if(fpc, 32'h0);
      id_idle();
      check("fill", 1'b0, 1'b0, 32'h0);
      fpc = fpc + 32'd4;
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    fpc       = 32'h0050_0000;
    reset     = 1'b0;
    bus.stall = 1'b0;
    set_if(B1, 32'h0);
    id_idle();

    check("reset_0", 1'b0, 1'b0, 32'h0);
    check("reset_1", 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    fill(3);

    // Cold branch: not predicted, resolves taken seven stages later.
    set_if(B1, 32'h0); id_idle();
    check("cold_fetch", 1'b0, 1'b0, 32'h0);
    fill(6);
    set_if(fpc, 32'h0); set_id(B1, T1, 1'b0, 1'b1, 1'b1);
    check("cold_resolve", 1'b1, 1'b1, T1);

    // Local counter now weak-taken and BTB holds the target.
    set_if(B1, 32'h0); id_idle();
    check("trained_fetch", 1'b1, 1'b0, T1);
    fill(6);
    set_if(fpc, 32'h0); set_id(B1, T1, 1'b0, 1'b1, 1'b1);
    check("trained_resolve", 1'b0, 1'b0, 32'h0);

    set_if(B1, 32'h0); id_idle();
    check("trained_fetch2", 1'b1, 1'b0, T1);
    fill(6);
    set_if(fpc, 32'h0); set_id(B1, T1, 1'b0, 1'b1, 1'b0);
    check("nt_resolve", 1'b1, 1'b1, B1 + 32'd4);

    // Stall freezes recovery and IF redirects; pipe must hold the record.
    set_if(B1, 32'h0); id_idle();
    check("stall_fetch", 1'b1, 1'b0, T1);
    fill(6);
    bus.stall = 1'b1;
    set_if(B1, 32'h0); set_id(B1, T1, 1'b0, 1'b1, 1'b0);
    check("stall_hold0", 1'b0, 1'b0, 32'h0);
    check("stall_hold1", 1'b0, 1'b0, 32'h0);
    bus.stall = 1'b0;
    set_if(fpc, 32'h0);
    check("stall_release", 1'b1, 1'b1, B1 + 32'd4);

    // Second branch: wrong target, then alias invalidation.
    set_if(B2, 32'h0); id_idle();
    check("b2_cold_fetch", 1'b0, 1'b0, 32'h0);
    fill(6);
    set_if(fpc, 32'h0); set_id(B2, T2A, 1'b0, 1'b1, 1'b1);
    check("b2_cold_resolve", 1'b1, 1'b1, T2A);
    set_if(B2, 32'h0); id_idle();
    check("b2_fetch_a", 1'b1, 1'b0, T2A);
    fill(6);
    set_if(fpc, 32'h0); set_id(B2, T2B, 1'b0, 1'b1, 1'b1);
    check("b2_wrong_target", 1'b1, 1'b1, T2B);
    set_if(B2, 32'h0); id_idle();
    check("b2_fetch_b", 1'b1, 1'b0, T2B);
    fill(6);
    set_if(fpc, 32'h0); set_id(B2, 32'h0, 1'b0, 1'b0, 1'b0);
    check("b2_alias", 1'b1, 1'b1, B2 + 32'd4);
    set_if(B2, 32'h0); id_idle();
    check("b2_after_alias", 1'b0, 1'b0, 32'h0);
    fill(6);
    set_if(fpc, 32'h0); set_id(B2, T2B, 1'b0, 1'b1, 1'b1);
    check("b2_relearn", 1'b1, 1'b1, T2B);
    // Local counter was already strong-taken: must saturate, not wrap.
    set_if(B2, 32'h0); id_idle();
    check("b2_saturated", 1'b1, 1'b0, T2B);

    // Reset with a taken record in flight.
    reset = 1'b0;
    set_if(fpc, 32'h0); id_idle();
    check("reset_mid0", 1'b0, 1'b0, 32'h0);
    check("reset_mid1", 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    fill(7);
    set_if(B2, 32'h0); id_idle();
    check("post_reset_fetch", 1'b0, 1'b0, 32'h0);

`ifdef BRANCH_PREDICTOR_RAS_EN
    fill(7);
    set_if(fpc, 32'h0); set_id(32'h0040_0200, 32'h0040_0600, 1'b1, 1'b1, 1'b1);
    check("ras_jal", 1'b1, 1'b1, 32'h0040_0600);
    set_if(32'h0040_0700, 32'h03E0_0008); id_idle();
    check("ras_jr", 1'b1, 1'b0, 32'h0040_0208);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
